// File: rtl/mux_nx1_rr.sv
// ---------------------------------------------------------------------------
// mux_nx1_rr
//
// N-to-1 channel multiplexer with a single registered output stage. An input
// channel is chosen either by a fixed index (mode=0) or by a round-robin
// arbiter (mode=1). The chosen word lands in the output register one cycle
// after the input handshake. Nothing is buffered beyond that register.
//
// Parameters
//   WIDTH  data width per channel (1..64)
//   N      number of input channels (2..16)
//   SELW   select width, ceil(log2(N))
//
// Ports
//   clk        rising-edge clock for all state
//   rst        synchronous, active-high reset
//   in_data    packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (combinational, only the granted channel)
//   mode       0 = fixed select via sel, 1 = round-robin
//   sel        channel index used when mode=0
//   out_data   registered data of the last accepted word
//   out_valid  out_data holds a word not yet taken downstream
//   out_ready  downstream accepts while out_valid is high
//   out_sel    registered index of the channel that supplied out_data
//
// Output register states
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_EMPTY | out_valid=0, register free to load
//   ST_FULL  | out_valid=1, word waiting for out_ready
// ---------------------------------------------------------------------------
module mux_nx1_rr #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SELW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_sel
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

    // N expressed one bit wider than an index so it can be compared against
    // and subtracted from index sums without overflow.
    localparam logic [SELW:0] N_W     = (SELW+1)'(N);
    localparam logic [SELW-1:0] PTR_RST = SELW'(N - 1);

    out_state_t          state_q, state_d;
    logic [WIDTH-1:0]    data_q, data_d;
    logic [SELW-1:0]     out_sel_q, out_sel_d;
    logic [SELW-1:0]     ptr_q, ptr_d;

    logic                load_en;
    logic                fix_hit;
    logic                rr_hit;
    logic [SELW-1:0]     rr_idx;
    logic [SELW:0]       rr_cand;
    logic                grant_any;
    logic [SELW-1:0]     grant_idx;
    logic [N-1:0]        grant_vec;
    logic [WIDTH-1:0]    grant_data;

    // The register can take a new word when it is empty or when the word it
    // holds is leaving this cycle.
    assign load_en = (state_q == ST_EMPTY) || out_ready;

    // ------------------------------------------------------------------
    // Fixed-select arbitration. An out-of-range sel never grants, and
    // in_valid is only indexed once sel is known to be in range.
    // ------------------------------------------------------------------
    always_comb begin
        fix_hit = 1'b0;
        if ({1'b0, sel} < N_W) begin
            fix_hit = in_valid[sel];
        end
    end

    // ------------------------------------------------------------------
    // Round-robin arbitration: scan ptr+1, ptr+2, ... wrapping, ending at
    // ptr itself, so a lone requester wins no matter where ptr sits.
    // ptr is always < N, so the sum is < 2N and one subtract wraps it.
    // ------------------------------------------------------------------
    always_comb begin
        rr_hit  = 1'b0;
        rr_idx  = '0;
        rr_cand = '0;
        for (int k = 1; k <= N; k++) begin
            rr_cand = {1'b0, ptr_q} + (SELW+1)'(k);
            if (rr_cand >= N_W) begin
                rr_cand = rr_cand - N_W;
            end
            if (!rr_hit && in_valid[rr_cand[SELW-1:0]]) begin
                rr_hit = 1'b1;
                rr_idx = rr_cand[SELW-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Final grant (at most one) and the data it selects.
    // ------------------------------------------------------------------
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        if (mode) begin
            grant_any = rr_hit;
            grant_idx = rr_idx;
        end else begin
            grant_any = fix_hit;
            grant_idx = sel;
        end
    end

    always_comb begin
        grant_vec  = '0;
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_any && (grant_idx == SELW'(i))) begin
                grant_vec[i] = 1'b1;
                grant_data   = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Ready is withheld during reset: the register is being cleared on this
    // edge, so no upstream word may be considered accepted.
    assign in_ready = grant_vec & {N{load_en & ~rst}};

    // ------------------------------------------------------------------
    // Next-state for output register and arbitration pointer.
    // A grant always implies the channel's valid is high, so a grant with
    // load_en is a completed input transfer.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        out_sel_d = out_sel_q;
        ptr_d     = ptr_q;
        case (state_q)
            ST_EMPTY: begin
                if (grant_any) begin
                    state_d   = ST_FULL;
                    data_d    = grant_data;
                    out_sel_d = grant_idx;
                    ptr_d     = grant_idx;
                end
            end
            ST_FULL: begin
                if (out_ready) begin
                    if (grant_any) begin
                        data_d    = grant_data;
                        out_sel_d = grant_idx;
                        ptr_d     = grant_idx;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // ptr resets to N-1 so the first round-robin scan starts at channel 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_EMPTY;
            data_q    <= '0;
            out_sel_q <= '0;
            ptr_q     <= PTR_RST;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            out_sel_q <= out_sel_d;
            ptr_q     <= ptr_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux_nx1_rr.sv
// ---------------------------------------------------------------------------
// tb_mux_nx1_rr
//
// Directed bench for mux_nx1_rr with N=4, WIDTH=8. Inputs change 1 ns after
// a rising edge; registered outputs are read at that point and in_ready is
// read after inputs have settled, well before the next edge.
// ---------------------------------------------------------------------------
module tb_mux_nx1_rr;

    localparam int WIDTH = 8;
    localparam int N     = 4;
    localparam int SELW  = 2;

    logic                 clk;
    logic                 rst;
    logic [N*WIDTH-1:0]   in_data;
    logic [N-1:0]         in_valid;
    logic [N-1:0]         in_ready;
    logic                 mode;
    logic [SELW-1:0]      sel;
    logic [WIDTH-1:0]     out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [SELW-1:0]      out_sel;

    int n_chk;
    int n_bad;

    mux_nx1_rr #(
        .WIDTH (WIDTH),
        .N     (N),
        .SELW  (SELW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sel   (out_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [1:0] s, input logic [7:0] d);
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".sel"},   32'(out_sel),   32'(s));
        chk({tag, ".data"},  32'(out_data),  32'(d));
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;

        in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        in_valid  = 4'hF;
        mode      = 1'b1;
        sel       = 2'd0;
        out_ready = 1'b1;
        rst       = 1'b1;

        // Reset with requests pending: nothing may be accepted.
        settle();
        chk("rst_ready", 32'(in_ready), 32'h0);
        step();
        chk_out("rst0", 1'b0, 2'd0, 8'h00);
        chk("rst_ready2", 32'(in_ready), 32'h0);
        step();
        chk_out("rst1", 1'b0, 2'd0, 8'h00);

        // Round-robin, all valid: 0,1,2,3,0 back to back.
        rst = 1'b0;
        settle();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("rr_all_rdy%0d", k), 32'(in_ready), 32'(4'b0001 << (k % 4)));
            step();
            chk_out($sformatf("rr_all%0d", k), 1'b1, 2'(k % 4), 8'(8'hA0 + (k % 4)));
        end

        // ptr=0, channels 0 and 2 requesting: 2, 0, 2.
        in_valid = 4'b0101;
        settle();
        chk("rr5_rdy0", 32'(in_ready), 32'b0100);
        step();
        chk_out("rr5_0", 1'b1, 2'd2, 8'hA2);
        chk("rr5_rdy1", 32'(in_ready), 32'b0001);
        step();
        chk_out("rr5_1", 1'b1, 2'd0, 8'hA0);
        chk("rr5_rdy2", 32'(in_ready), 32'b0100);
        step();
        chk_out("rr5_2", 1'b1, 2'd2, 8'hA2);

        // Fixed select ch3, then a 3-cycle downstream stall.
        mode     = 1'b0;
        sel      = 2'd3;
        in_valid = 4'b1000;
        settle();
        chk("fix_rdy", 32'(in_ready), 32'b1000);
        step();
        chk_out("fix_load", 1'b1, 2'd3, 8'hA3);
        out_ready = 1'b0;
        in_data[3*WIDTH +: WIDTH] = 8'h5C;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk($sformatf("stall_rdy%0d", k), 32'(in_ready), 32'h0);
            step();
            chk_out($sformatf("stall%0d", k), 1'b1, 2'd3, 8'hA3);
        end
        out_ready = 1'b1;
        settle();
        chk("release_rdy", 32'(in_ready), 32'b1000);
        step();
        chk_out("release", 1'b1, 2'd3, 8'h5C);

        // Fixed select on an idle channel: no grant, register drains.
        in_valid = 4'b0111;
        settle();
        chk("idle_rdy", 32'(in_ready), 32'h0);
        step();
        chk("idle_v0", 32'(out_valid), 32'h0);
        step();
        chk("idle_v1", 32'(out_valid), 32'h0);

        // Mode switch mid-stream. ptr=3, so round-robin starts at ch0.
        in_data[3*WIDTH +: WIDTH] = 8'hA3;
        mode     = 1'b1;
        in_valid = 4'hF;
        settle();
        chk("sw_rdy0", 32'(in_ready), 32'b0001);
        step();
        chk_out("sw0", 1'b1, 2'd0, 8'hA0);
        mode = 1'b0;
        sel  = 2'd1;
        settle();
        chk("sw_rdy1", 32'(in_ready), 32'b0010);
        step();
        chk_out("sw1", 1'b1, 2'd1, 8'hA1);
        mode = 1'b1;
        settle();
        chk("sw_rdy2", 32'(in_ready), 32'b0100);
        step();
        chk_out("sw2", 1'b1, 2'd2, 8'hA2);

        // Mode/sel change during a stall leaves the held word alone.
        out_ready = 1'b0;
        mode      = 1'b0;
        sel       = 2'd0;
        step();
        chk_out("hold_mode", 1'b1, 2'd2, 8'hA2);

        // Reset while full and stalled discards the word.
        rst = 1'b1;
        settle();
        chk("rst_full_rdy", 32'(in_ready), 32'h0);
        step();
        chk_out("rst_full", 1'b0, 2'd0, 8'h00);
        out_ready = 1'b1;
        settle();
        chk("rst_full_rdy2", 32'(in_ready), 32'h0);
        step();
        rst  = 1'b0;
        mode = 1'b1;
        settle();
        chk("post_rst_rdy", 32'(in_ready), 32'b0001);
        step();
        chk_out("post_rst", 1'b1, 2'd0, 8'hA0);

        // Single requester wins every cycle, including across the wrap.
        in_valid = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk($sformatf("solo3_rdy%0d", k), 32'(in_ready), 32'b1000);
            step();
            chk_out($sformatf("solo3_%0d", k), 1'b1, 2'd3, 8'hA3);
        end
        in_valid = 4'b0001;
        for (int k = 0; k < 2; k++) begin
            settle();
            chk($sformatf("solo0_rdy%0d", k), 32'(in_ready), 32'b0001);
            step();
            chk_out($sformatf("solo0_%0d", k), 1'b1, 2'd0, 8'hA0);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/mux_nx1_rr.md
MUX_NX1_RR -- requirements
Module: mux_nx1_rr

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning data width per channel (1..64).
REQ-002 The block SHALL have parameter N, default 4, meaning input channel count (2..16).
REQ-003 The block SHALL have parameter SELW, default 2, meaning select width; SELW = ceil(log2(N)).
REQ-004 Port clk  input  1  single clock; all logic on rising edge.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 Port in_valid  input  N  per-channel valid.
REQ-008 Port in_ready  output  N  per-channel ready; combinational.
REQ-009 Port mode  input  1  0 = fixed select via sel, 1 = round-robin.
REQ-010 Port sel  input  SELW  channel index used when mode=0.
REQ-011 Port out_data  output  WIDTH  registered selected data.
REQ-012 Port out_valid  output  1  out_data holds an unconsumed word.
REQ-013 Port out_ready  input  1  downstream accepts when high with out_valid.
REQ-014 Port out_sel  output  SELW  registered index of the channel that supplied out_data.

Function
REQ-015 Output register SHALL have two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 load_en SHALL be (out_valid=0) OR (out_ready=1); the register loads only when load_en=1 and a grant exists.
REQ-017 Exactly one or zero grants per cycle; in_ready[i] = grant[i] AND load_en; in_ready SHALL be zero for all non-granted channels.
REQ-018 Transfer on channel i occurs when in_valid[i] AND in_ready[i]; on that edge out_data <= channel i data, out_sel <= i, out_valid <= 1.
REQ-019 Latency SHALL be 1 cycle from input transfer to out_valid; throughput 1 word/cycle with out_ready held high.
REQ-020 FULL with out_ready=1 and no grant: out_valid <= 0 (FULL->EMPTY); with a grant: reload, stay FULL.
REQ-021 FULL with out_ready=0: out_data, out_sel, out_valid SHALL hold unchanged; all in_ready=0.
REQ-022 mode=0: grant = sel if sel < N and in_valid[sel]=1; sel >= N SHALL produce no grant.
REQ-023 mode=1: grant = first channel with in_valid=1 searching ptr+1, ptr+2, ... wrapping modulo N, ending at ptr itself.
REQ-024 ptr (SELW bits) SHALL update to the granted index only on a completed input transfer, in either mode.
REQ-025 Wrap-around: ptr=N-1 SHALL search from channel 0; single requester SHALL be granted every cycle regardless of ptr.
REQ-026 mode or sel change SHALL affect only the next arbitration; a held FULL word is unaffected.
REQ-027 in_valid dropping while not granted SHALL have no effect; no input data is buffered beyond the output register.

Reset
REQ-028 rst=1 at a rising edge SHALL force out_valid=0, out_data=0, out_sel=0, ptr=N-1 (channel 0 first priority), overriding any simultaneous transfer.
REQ-029 While rst=1, in_ready SHALL be all zero; a word held mid-stall SHALL be discarded.
REQ-030 First arbitration after reset deassertion SHALL occur on the first edge with rst=0.

Verification
REQ-031 N=4,W=8, mode=1, all in_valid=1, out_ready=1, data ch i = 8'hA0+i -> out_sel 0,1,2,3,0 on consecutive cycles, out_data A0,A1,A2,A3,A0.
REQ-032 mode=1, in_valid=4'b0101, ptr=0 -> grant ch2, then ch0, then ch2; ch1/ch3 in_ready stay 0.
REQ-033 mode=0, sel=3, in_valid[3]=1, out_ready=0 for 3 cycles -> one word loaded, out_data/out_sel stable, in_ready=0 during stall; release -> next word 1 cycle later.
REQ-034 mode=0, sel=3 with in_valid[3]=0 while others valid -> no grant, out_valid falls after consumption.
REQ-035 rst asserted while FULL and out_ready=0 -> next edge out_valid=0, out_data=0, out_sel=0; post-reset first RR grant goes to channel 0.
REQ-036 Switch mode 1->0 mid-stream with sel=1 -> next grant ch1 only; returning to mode 1 resumes from ptr=1 (ch2 next if valid).
